// File: rtl/adaptive_slicer_pkg.sv
// adaptive_slicer_pkg
// Shared definitions for the adaptive 4-PAM slicer: symbol encoding and
// default parameter values used by adaptive_slicer and pam4_slice_map.
package adaptive_slicer_pkg;

    localparam int                 DEF_WIDTH    = 18;
    localparam int                 DEF_LOG2_N   = 10;
    localparam logic signed [17:0] DEF_REF_INIT = 18'sd32768;

    // Gray-coded 4-PAM symbols: adjacent levels differ in one bit.
    typedef enum logic [1:0] {
        SYM_M3 = 2'b00,
        SYM_M1 = 2'b01,
        SYM_P1 = 2'b11,
        SYM_P3 = 2'b10
    } sym_t;

endpackage

// File: rtl/adaptive_slicer_pam4_slice_map.sv
// pam4_slice_map
// Combinational 4-PAM decision and level mapping against a reference level.
//   dec_var  in   WIDTH signed  decision variable
//   ref_lvl  in   WIDTH signed  reference (outer threshold, equal to 2b)
//   sym      out  sym_t         sliced symbol
//   level    out  WIDTH signed  mapped level (-3b, -b, +b, +3b), saturated
module pam4_slice_map
    import adaptive_slicer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] dec_var,
    input  logic signed [WIDTH-1:0] ref_lvl,
    output sym_t                    sym,
    output logic signed [WIDTH-1:0] level
);

    // One guard bit so -ref and 3b never wrap before saturation.
    logic signed [WIDTH:0] dv_x;
    logic signed [WIDTH:0] ref_x;
    logic signed [WIDTH:0] neg_ref_x;
    logic signed [WIDTH:0] b_x;
    logic signed [WIDTH:0] b3_x;
    logic signed [WIDTH:0] lvl_x;

    assign dv_x      = (WIDTH+1)'(dec_var);
    assign ref_x     = (WIDTH+1)'(ref_lvl);
    assign neg_ref_x = -ref_x;
    assign b_x       = ref_x >>> 1;
    assign b3_x      = ref_x + b_x;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else chain can leave it unassigned (latch).
    always_comb begin
        sym   = SYM_P1;
        lvl_x = b_x;
        if (dv_x >= ref_x) begin
            sym   = SYM_P3;
            lvl_x = b3_x;
        end else if (dv_x <= neg_ref_x) begin
            sym   = SYM_M3;
            lvl_x = -b3_x;
        end else if (dv_x[WIDTH] || (dv_x == '0)) begin
            sym   = SYM_M1;
            lvl_x = -b_x;
        end
    end

    // 3b exceeds the WIDTH range once ref passes 2/3 of full scale; clamp.
    assign level = (lvl_x[WIDTH] != lvl_x[WIDTH-1])
                 ? {lvl_x[WIDTH], {(WIDTH-1){~lvl_x[WIDTH]}}}
                 : lvl_x[WIDTH-1:0];

endmodule

// File: rtl/adaptive_slicer.sv
// adaptive_slicer
// 4-PAM slicer whose reference level tracks the mean absolute value of the
// input over windows of 2^LOG2_N valid samples. Outputs are registered with
// one cycle of latency and hold their last value while in_valid is low.
// Optional feature: define ADAPTIVE_SLICER_ERR_EN to add the err_out port
// (dec_var minus mapped level, saturated to WIDTH bits).
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   in_valid     in   dec_var qualifier
//   dec_var      in   WIDTH signed decision variable
//   adapt_en     in   enable reference adaptation (low freezes acc/counter)
//   ref_load     in   one-cycle strobe: ref_level <= ref_init, restart window
//   ref_init     in   WIDTH signed value loaded by ref_load
//   out_valid    out  qualifies slice_out / out_map_out / err_out
//   slice_out    out  2-bit symbol (00=-3b, 01=-b, 11=+b, 10=+3b)
//   out_map_out  out  WIDTH signed mapped level
//   err_out      out  WIDTH signed slicer error (ADAPTIVE_SLICER_ERR_EN only)
//   ref_level    out  WIDTH signed current reference
//   ref_update   out  one-cycle pulse when a window completes
module adaptive_slicer
    import adaptive_slicer_pkg::*;
#(
    parameter int                      WIDTH    = DEF_WIDTH,
    parameter int                      LOG2_N   = DEF_LOG2_N,
    parameter logic signed [WIDTH-1:0] REF_INIT = DEF_REF_INIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] dec_var,
    input  logic                    adapt_en,
    input  logic                    ref_load,
    input  logic signed [WIDTH-1:0] ref_init,
    output logic                    out_valid,
    output logic [1:0]              slice_out,
    output logic signed [WIDTH-1:0] out_map_out,
`ifdef ADAPTIVE_SLICER_ERR_EN
    output logic signed [WIDTH-1:0] err_out,
`endif
    output logic signed [WIDTH-1:0] ref_level,
    output logic                    ref_update
);

    // |dec_var| < 2^(WIDTH-1), so 2^LOG2_N of them fit without overflow.
    localparam int ACC_W = WIDTH + LOG2_N;

    sym_t                    sym;
    logic signed [WIDTH-1:0] level;
    logic signed [WIDTH-1:0] neg_dv;
    logic [WIDTH-1:0]        mag;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_next;
    logic [LOG2_N-1:0]       cnt;

    // Slicing always uses the registered reference, so a sample landing in
    // an update or load cycle sees the old value.
    pam4_slice_map #(
        .WIDTH   (WIDTH)
    ) u_slice_map (
        .dec_var (dec_var),
        .ref_lvl (ref_level),
        .sym     (sym),
        .level   (level)
    );

    // Negating the most-negative code wraps back to itself; clamp to max.
    assign neg_dv = -dec_var;
    assign mag    = !dec_var[WIDTH-1] ? dec_var
                  : neg_dv[WIDTH-1]   ? {1'b0, {(WIDTH-1){1'b1}}}
                  :                     neg_dv;

    assign acc_next = acc + ACC_W'(mag);

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_level   <= REF_INIT;
            acc         <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            slice_out   <= SYM_M3;
            out_map_out <= '0;
            ref_update  <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            ref_update <= 1'b0;
            if (in_valid) begin
                slice_out   <= sym;
                out_map_out <= level;
            end

            if (ref_load) begin
                ref_level <= ref_init;
                acc       <= '0;
                cnt       <= '0;
            end else if (adapt_en && in_valid) begin
                if (cnt == '1) begin
                    // Mean of |x| over the window: the top WIDTH bits of the
                    // completed sum; the MSB is always zero.
                    ref_level  <= $signed(acc_next[ACC_W-1:LOG2_N]);
                    acc        <= '0;
                    cnt        <= '0;
                    ref_update <= 1'b1;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef ADAPTIVE_SLICER_ERR_EN
    logic signed [WIDTH:0]   err_x;
    logic signed [WIDTH-1:0] err_sat;

    assign err_x   = (WIDTH+1)'(dec_var) - (WIDTH+1)'(level);
    assign err_sat = (err_x[WIDTH] != err_x[WIDTH-1])
                   ? {err_x[WIDTH], {(WIDTH-1){~err_x[WIDTH]}}}
                   : err_x[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            err_out <= '0;
        end else if (in_valid) begin
            err_out <= err_sat;
        end
    end
`else
    // Error output disabled: no error datapath is built.
`endif

endmodule

// File: tb/tb_adaptive_slicer.sv
// tb_adaptive_slicer
// Self-checking bench for adaptive_slicer (WIDTH=18, LOG2_N=2, REF_INIT=32768).
// A behavioural model computes expected outputs from the slicing and
// mean-abs adaptation rules; one compare process checks every cycle, and
// directed sequences pin the model with hand-computed values.
module tb_adaptive_slicer;

    localparam int                 WIDTH    = 18;
    localparam int                 LOG2_N   = 2;
    localparam logic signed [17:0] REF_INIT = 18'sd32768;
    localparam int                 N        = 1 << LOG2_N;
    localparam int                 VMAX     = (1 << (WIDTH - 1)) - 1;
    localparam int                 VMIN     = -(1 << (WIDTH - 1));

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic signed [WIDTH-1:0] dec_var;
    logic                    adapt_en;
    logic                    ref_load;
    logic signed [WIDTH-1:0] ref_init;
    logic                    out_valid;
    logic [1:0]              slice_out;
    logic signed [WIDTH-1:0] out_map_out;
`ifdef ADAPTIVE_SLICER_ERR_EN
    logic signed [WIDTH-1:0] err_out;
`endif
    logic signed [WIDTH-1:0] ref_level;
    logic                    ref_update;

    adaptive_slicer #(
        .WIDTH       (WIDTH),
        .LOG2_N      (LOG2_N),
        .REF_INIT    (REF_INIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .dec_var     (dec_var),
        .adapt_en    (adapt_en),
        .ref_load    (ref_load),
        .ref_init    (ref_init),
        .out_valid   (out_valid),
        .slice_out   (slice_out),
        .out_map_out (out_map_out),
`ifdef ADAPTIVE_SLICER_ERR_EN
        .err_out     (err_out),
`endif
        .ref_level   (ref_level),
        .ref_update  (ref_update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         rlev;
        int         acc;
        int         cnt;
        logic       valid;
        logic [1:0] sym;
        int         map;
        int         err;
        logic       upd;
    } model_t;

    model_t m;

    function automatic int sat(input int v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    function automatic model_t step(input model_t s, input logic rst,
                                    input logic v, input logic ae,
                                    input logic ld, input int dv, input int li);
        model_t n = s;
        int b;
        int b3;
        int mag;
        if (rst) begin
            n.rlev = REF_INIT; n.acc = 0; n.cnt = 0; n.valid = 1'b0;
            n.sym = 2'b00; n.map = 0; n.err = 0; n.upd = 1'b0;
            return n;
        end
        n.upd   = 1'b0;
        n.valid = v;
        if (v) begin
            b  = s.rlev >>> 1;
            b3 = s.rlev + b;
            if (dv >= s.rlev)       begin n.sym = 2'b10; n.map = sat(b3);  end
            else if (dv <= -s.rlev) begin n.sym = 2'b00; n.map = sat(-b3); end
            else if (dv <= 0)       begin n.sym = 2'b01; n.map = -b;       end
            else                    begin n.sym = 2'b11; n.map = b;        end
            n.err = sat(dv - n.map);
        end
        if (ld) begin
            n.rlev = li; n.acc = 0; n.cnt = 0;
        end else if (ae && v) begin
            mag   = (dv == VMIN) ? VMAX : ((dv < 0) ? -dv : dv);
            n.acc = s.acc + mag;
            n.cnt = s.cnt + 1;
            if (n.cnt == N) begin
                n.rlev = n.acc / N;
                n.acc  = 0;
                n.cnt  = 0;
                n.upd  = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= step(m, reset, in_valid, adapt_en, ref_load, int'(dec_var), int'(ref_init));

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid",   out_valid,   m.valid);
            check("slice_out",   slice_out,   m.sym);
            check("out_map_out", out_map_out, m.map);
            check("ref_level",   ref_level,   m.rlev);
            check("ref_update",  ref_update,  m.upd);
`ifdef ADAPTIVE_SLICER_ERR_EN
            check("err_out",     err_out,     m.err);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input int dv, input logic ae,
                       input logic ld = 1'b0, input int li = 0,
                       input logic rst = 1'b0);
        reset    = rst;
        in_valid = v;
        dec_var  = WIDTH'(dv);
        adapt_en = ae;
        ref_load = ld;
        ref_init = WIDTH'(li);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        int bdv[4];
        int bsym[4];
        int bmap[4];
        int r;
        int dv;
        bdv  = '{-32768, 0, 1, 32768};
        bsym = '{0, 1, 3, 2};
        bmap = '{-49152, -16384, 16384, 49152};

        do_reset();
        do_reset();
        check("rst out_valid",  out_valid,   0);
        check("rst ref_level",  ref_level,   32768);
        check("rst slice_out",  slice_out,   0);
        check("rst map",        out_map_out, 0);
        check("rst ref_update", ref_update,  0);
        chk_en = 1'b1;

        // First sample after reset, upper outer region.
        cyc(1'b1, 40000, 1'b0);
        check("first slice", slice_out,   2);
        check("first map",   out_map_out, 49152);
        check("first valid", out_valid,   1);

        // Threshold boundaries.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, bdv[i], 1'b0);
            check("bound slice", slice_out,   bsym[i]);
            check("bound map",   out_map_out, bmap[i]);
        end

        // Idle cycle: outputs hold, out_valid drops.
        cyc(1'b0, 5, 1'b0);
        check("idle valid", out_valid,   0);
        check("idle slice", slice_out,   2);
        check("idle map",   out_map_out, 49152);

        // One adaptation window.
        do_reset();
        cyc(1'b1, 20000, 1'b1);
        cyc(1'b1, -20000, 1'b1);
        cyc(1'b1, 24000, 1'b1);
        check("win3 upd", ref_update, 0);
        cyc(1'b1, -16000, 1'b1);
        check("win4 upd",   ref_update,  1);
        check("win4 ref",   ref_level,   20000);
        check("win4 slice", slice_out,   1);
        check("win4 map",   out_map_out, -16384);
        cyc(1'b1, 20000, 1'b1);
        check("post slice", slice_out,   2);
        check("post map",   out_map_out, 30000);
        check("post upd",   ref_update,  0);

        // ref_load coincident with the window-closing sample.
        do_reset();
        cyc(1'b1, 20000, 1'b1);
        cyc(1'b1, -20000, 1'b1);
        cyc(1'b1, 24000, 1'b1);
        cyc(1'b1, -16000, 1'b1, 1'b1, 10000);
        check("load ref",   ref_level,   10000);
        check("load upd",   ref_update,  0);
        check("load slice", slice_out,   1);
        check("load map",   out_map_out, -16384);
        cyc(1'b1, 12000, 1'b1);
        check("newref slice", slice_out,   2);
        check("newref map",   out_map_out, 15000);
        cyc(1'b1, 12000, 1'b1);
        cyc(1'b1, 12000, 1'b1);
        check("restart3 upd", ref_update, 0);
        cyc(1'b1, 12000, 1'b1);
        check("restart4 upd", ref_update, 1);
        check("restart4 ref", ref_level,  12000);

        // adapt_en pause mid-window keeps the partial sum.
        do_reset();
        cyc(1'b1, 40000, 1'b1);
        cyc(1'b1, 40000, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, -77777, 1'b0);
        check("pause ref", ref_level, 32768);
        cyc(1'b1, 8000, 1'b1);
        check("resume3 upd", ref_update, 0);
        cyc(1'b1, 8000, 1'b1);
        check("resume4 upd", ref_update, 1);
        check("resume4 ref", ref_level,  24000);

        // Most-negative input saturates |x|; mapped level saturates too.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, VMIN, 1'b1);
            check("mneg slice", slice_out,   0);
            check("mneg map",   out_map_out, -49152);
        end
        check("mneg ref", ref_level, 131071);
        cyc(1'b1, VMAX, 1'b0);
        check("sat p3 slice", slice_out,   2);
        check("sat p3 map",   out_map_out, 131071);
        cyc(1'b1, VMIN, 1'b0);
        check("sat m3 map",   out_map_out, VMIN);

        // Reset mid-window dominates ref_load and in_valid.
        cyc(1'b1, 5000, 1'b1);
        cyc(1'b1, 5000, 1'b1);
        cyc(1'b1, 5000, 1'b1, 1'b1, 777, 1'b1);
        check("rstdom ref",   ref_level,  32768);
        check("rstdom valid", out_valid,  0);
        check("rstdom upd",   ref_update, 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4000, 1'b1);
        check("rwin3 upd", ref_update, 0);
        cyc(1'b1, 4000, 1'b1);
        check("rwin4 upd", ref_update, 1);
        check("rwin4 ref", ref_level,  4000);

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 7));
            case (r)
                0:       dv = VMIN;
                1:       dv = VMAX;
                2:       dv = m.rlev;
                3:       dv = -m.rlev + int'($urandom_range(0, 2)) - 1;
                4:       dv = int'($urandom_range(0, 2)) - 1;
                5:       dv = int'($urandom_range(0, 80000)) - 40000;
                default: dv = int'($urandom_range(0, (1 << WIDTH) - 1)) + VMIN;
            endcase
            cyc(($urandom_range(0, 3) != 0), dv, ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 63) == 0), int'($urandom_range(1, VMAX)),
                ($urandom_range(0, 499) == 0));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
